// File: rtl/calculator_seq.sv
// Sequential calculator: accumulator with add/sub/clear executed in one cycle and
// signed multiply/divide run as BITS-iteration shift-add / restoring datapaths.
module calculator_seq #(
   parameter int BITS     = 32,
   parameter int SW_BITS  = 16,
   parameter bit SATURATE = 1'b0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [4:0]         buttons,
   input  logic [SW_BITS-1:0] switch,
   output logic [BITS-1:0]    accum,
   output logic               busy,
   output logic               done,
   output logic               ovf,
   output logic               div_by_zero
);

   localparam int              CW    = $clog2(BITS) + 1;
   localparam logic [CW-1:0]   ITERS = CW'(BITS);
   localparam logic [BITS-1:0] MAX_V = {1'b0, {(BITS-1){1'b1}}};
   localparam logic [BITS-1:0] MIN_V = {1'b1, {(BITS-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, EXEC, MUL, DIV} state_t;
   typedef enum logic [1:0] {OP_NOP, OP_CLR, OP_ADD, OP_SUB} op_t;

   state_t              state_r;
   op_t                 op_r;
   logic [BITS-1:0]     opnd_r;
   logic [BITS-1:0]     mag_b_r;
   logic                neg_r;
   logic [CW-1:0]       cnt_r;
   logic [2*BITS-1:0]   p_r;

   logic [BITS-1:0]     opnd_ext_s;
   logic [BITS-1:0]     add_s, sub_s, add_res_s, sub_res_s;
   logic                add_ovf_s, sub_ovf_s;
   logic [BITS:0]       mul_sum_s;
   logic [BITS:0]       div_shift_s, div_trial_s;
   logic [BITS-1:0]     div_rem_next_s;
   logic [2*BITS-1:0]   mul_full_s;
   logic                mul_ovf_s, div_ovf_s;
   logic [BITS-1:0]     mul_res_s, div_val_s, div_res_s;

   function automatic logic [BITS-1:0] magnitude(input logic [BITS-1:0] v);
      if (v[BITS-1]) begin
         return (~v) + BITS'(1'b1);
      end else begin
         return v;
      end
   endfunction

   function automatic logic [BITS-1:0] sat_limit(input logic negative);
      if (negative) begin
         return MIN_V;
      end else begin
         return MAX_V;
      end
   endfunction

   assign opnd_ext_s = BITS'($signed(switch));

   // Result, overflow and per-iteration datapath terms
   always_comb begin
      add_s       = accum + opnd_r;
      sub_s       = accum - opnd_r;
      add_ovf_s   = (accum[BITS-1] == opnd_r[BITS-1]) && (add_s[BITS-1] != accum[BITS-1]);
      sub_ovf_s   = (accum[BITS-1] != opnd_r[BITS-1]) && (sub_s[BITS-1] != accum[BITS-1]);
      mul_sum_s   = {1'b0, p_r[2*BITS-1:BITS]} +
                    (p_r[0] ? {1'b0, mag_b_r} : {(BITS+1){1'b0}});
      div_shift_s = {p_r[2*BITS-1:BITS], p_r[BITS-1]};
      div_trial_s = div_shift_s - {1'b0, mag_b_r};
      // A borrow out of the trial subtraction means the divisor did not fit: restore
      if (div_trial_s[BITS]) begin
         div_rem_next_s = div_shift_s[BITS-1:0];
      end else begin
         div_rem_next_s = div_trial_s[BITS-1:0];
      end
      if (neg_r) begin
         mul_full_s = (~p_r) + (2*BITS)'(1'b1);
         div_val_s  = (~p_r[BITS-1:0]) + BITS'(1'b1);
      end else begin
         mul_full_s = p_r;
         div_val_s  = p_r[BITS-1:0];
      end
      mul_ovf_s = !((&mul_full_s[2*BITS-1:BITS-1]) || !(|mul_full_s[2*BITS-1:BITS-1]));
      div_ovf_s = p_r[BITS-1] && !neg_r;
      if (SATURATE && add_ovf_s) begin
         add_res_s = sat_limit(accum[BITS-1]);
      end else begin
         add_res_s = add_s;
      end
      if (SATURATE && sub_ovf_s) begin
         sub_res_s = sat_limit(accum[BITS-1]);
      end else begin
         sub_res_s = sub_s;
      end
      if (SATURATE && mul_ovf_s) begin
         mul_res_s = sat_limit(mul_full_s[2*BITS-1]);
      end else begin
         mul_res_s = mul_full_s[BITS-1:0];
      end
      if (SATURATE && div_ovf_s) begin
         div_res_s = MAX_V;
      end else begin
         div_res_s = div_val_s;
      end
   end

   // Control FSM, iteration datapath registers and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= IDLE;
         op_r        <= OP_NOP;
         opnd_r      <= {BITS{1'b0}};
         mag_b_r     <= {BITS{1'b0}};
         neg_r       <= 1'b0;
         cnt_r       <= {CW{1'b0}};
         p_r         <= {(2*BITS){1'b0}};
         accum       <= {BITS{1'b0}};
         busy        <= 1'b0;
         done        <= 1'b0;
         ovf         <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_r)
            IDLE: begin
               if (start) begin
                  opnd_r  <= opnd_ext_s;
                  mag_b_r <= magnitude(opnd_ext_s);
                  neg_r   <= accum[BITS-1] ^ opnd_ext_s[BITS-1];
                  p_r     <= {{BITS{1'b0}}, magnitude(accum)};
                  cnt_r   <= {CW{1'b0}};
                  busy    <= 1'b1;
                  if (buttons[0]) begin
                     state_r <= MUL;
                  end else if (buttons[1]) begin
                     op_r    <= OP_CLR;
                     state_r <= EXEC;
                  end else if (buttons[2]) begin
                     op_r    <= OP_ADD;
                     state_r <= EXEC;
                  end else if (buttons[3]) begin
                     op_r    <= OP_SUB;
                     state_r <= EXEC;
                  end else if (buttons[4]) begin
                     state_r <= DIV;
                  end else begin
                     op_r    <= OP_NOP;
                     state_r <= EXEC;
                  end
               end
            end
            EXEC: begin
               case (op_r)
                  OP_ADD: begin
                     accum <= add_res_s;
                     ovf   <= add_ovf_s;
                  end
                  OP_SUB: begin
                     accum <= sub_res_s;
                     ovf   <= sub_ovf_s;
                  end
                  OP_CLR: begin
                     accum <= {BITS{1'b0}};
                     ovf   <= 1'b0;
                  end
                  default: ovf <= 1'b0;
               endcase
               div_by_zero <= 1'b0;
               done        <= 1'b1;
               busy        <= 1'b0;
               state_r     <= IDLE;
            end
            MUL: begin
               if (cnt_r != ITERS) begin
                  p_r   <= {mul_sum_s, p_r[BITS-1:1]};
                  cnt_r <= cnt_r + CW'(1'b1);
               end else begin
                  accum       <= mul_res_s;
                  ovf         <= mul_ovf_s;
                  div_by_zero <= 1'b0;
                  done        <= 1'b1;
                  busy        <= 1'b0;
                  state_r     <= IDLE;
               end
            end
            DIV: begin
               if (cnt_r != ITERS) begin
                  p_r   <= {div_rem_next_s, p_r[BITS-2:0], ~div_trial_s[BITS]};
                  cnt_r <= cnt_r + CW'(1'b1);
               end else begin
                  if (mag_b_r == {BITS{1'b0}}) begin
                     div_by_zero <= 1'b1;
                     ovf         <= 1'b0;
                  end else begin
                     accum       <= div_res_s;
                     ovf         <= div_ovf_s;
                     div_by_zero <= 1'b0;
                  end
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  state_r <= IDLE;
               end
            end
            default: begin
               busy    <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_calculator_seq.sv
// Bench for calculator_seq: three instances (32-bit wrap, 8-bit wrap, 8-bit saturate)
// driven in lockstep and compared against an integer-arithmetic reference model.
module tb_calculator_seq;

   logic        clk = 1'b0;
   logic        reset, start;
   logic [4:0]  buttons;
   logic [15:0] sw16;
   logic [7:0]  sw8;
   logic [31:0] acc32;
   logic [7:0]  acc8w, acc8s;
   logic [2:0]  busy_v, done_v, ovf_v, dbz_v;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int dcount[3] = '{0, 0, 0};
   int dcyc[3]   = '{0, 0, 0};
   logic dbusy[3];
   longint m_acc[3];
   bit m_ovf[3], m_dbz[3];
   int bits_a[3] = '{32, 8, 8};
   bit sat_a[3]  = '{1'b0, 1'b0, 1'b1};

   always #5 clk = ~clk;

   calculator_seq #(.BITS(32), .SW_BITS(16), .SATURATE(1'b0)) dut32 (
      .clk(clk), .reset(reset), .start(start), .buttons(buttons), .switch(sw16),
      .accum(acc32), .busy(busy_v[0]), .done(done_v[0]), .ovf(ovf_v[0]), .div_by_zero(dbz_v[0]));
   calculator_seq #(.BITS(8), .SW_BITS(8), .SATURATE(1'b0)) dut8w (
      .clk(clk), .reset(reset), .start(start), .buttons(buttons), .switch(sw8),
      .accum(acc8w), .busy(busy_v[1]), .done(done_v[1]), .ovf(ovf_v[1]), .div_by_zero(dbz_v[1]));
   calculator_seq #(.BITS(8), .SW_BITS(8), .SATURATE(1'b1)) dut8s (
      .clk(clk), .reset(reset), .start(start), .buttons(buttons), .switch(sw8),
      .accum(acc8s), .busy(busy_v[2]), .done(done_v[2]), .ovf(ovf_v[2]), .div_by_zero(dbz_v[2]));

   always @(posedge clk) cyc <= cyc + 1;

   // Record every done pulse: how many, when, and whether busy was still high
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (done_v[i] === 1'b1) begin
            dcount[i] <= dcount[i] + 1;
            dcyc[i]   <= cyc;
            dbusy[i]  <= busy_v[i];
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   function automatic logic signed [63:0] acc_of(int i);
      if (i == 0) return 64'($signed(acc32));
      else if (i == 1) return 64'($signed(acc8w));
      else return 64'($signed(acc8s));
   endfunction

   task automatic check(input string tag, input int i,
                        input logic signed [63:0] obs, input logic signed [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s dut%0d observed=%0d expected=%0d", tag, i, obs, exp);
      end
   endtask

   // Reference: true integer result, then wrap or clamp into the instance's width
   function automatic void model(int i, logic [4:0] btn, logic [15:0] sw);
      longint op, r, mx, mn, m, w;
      bit ov;
      int b;
      b = bits_a[i];
      if (b == 32) op = longint'($signed(sw));
      else op = longint'($signed(sw[7:0]));
      m  = longint'(1) <<< b;
      mx = m / 2 - 1;
      mn = -(m / 2);
      m_dbz[i] = 1'b0;
      r = m_acc[i];
      if (btn[0]) r = m_acc[i] * op;
      else if (btn[1]) r = 0;
      else if (btn[2]) r = m_acc[i] + op;
      else if (btn[3]) r = m_acc[i] - op;
      else if (btn[4]) begin
         if (op == 0) m_dbz[i] = 1'b1;
         else r = m_acc[i] / op;
      end
      ov = (r > mx) || (r < mn);
      if (ov && sat_a[i]) r = (r > mx) ? mx : mn;
      else if (ov) begin
         w = r & (m - 1);
         r = (w > mx) ? w - m : w;
      end
      m_acc[i] = r;
      m_ovf[i] = ov;
   endfunction

   task automatic check_state(input string tag);
      for (int i = 0; i < 3; i++) begin
         check({tag, "_accum"}, i, acc_of(i), m_acc[i]);
         check({tag, "_ovf"}, i, ovf_v[i], m_ovf[i]);
         check({tag, "_dbz"}, i, dbz_v[i], m_dbz[i]);
         check({tag, "_busy"}, i, busy_v[i], 0);
         check({tag, "_done"}, i, done_v[i], 0);
      end
   endtask

   task automatic do_op(input logic [4:0] btn, input logic [15:0] sw, input int pulse_at);
      int base[3];
      int n, k, lat;
      bit all, seq;
      @(negedge clk);
      for (int i = 0; i < 3; i++) base[i] = dcount[i];
      buttons = btn; sw16 = sw; sw8 = sw[7:0]; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = cyc;
      for (int i = 0; i < 3; i++) check("busy_after_accept", i, busy_v[i], 1);
      k = 0; all = 1'b0;
      while (!all && k < 100) begin
         if (k == pulse_at) begin
            start = 1'b1; buttons = 5'b00010;
         end else start = 1'b0;
         @(negedge clk);
         k++;
         all = 1'b1;
         for (int i = 0; i < 3; i++) if (dcount[i] == base[i]) all = 1'b0;
      end
      start = 1'b0;
      repeat (3) @(negedge clk);
      seq = btn[0] | (btn[4] & ~(|btn[3:1]));
      for (int i = 0; i < 3; i++) begin
         lat = seq ? bits_a[i] + 1 : 1;
         model(i, btn, sw);
         check("done_count", i, dcount[i] - base[i], 1);
         check("done_cycle", i, dcyc[i], n + lat);
         check("busy_at_done", i, dbusy[i], 0);
      end
      check_state("op");
   endtask

   initial begin
      int base[3];
      logic [4:0]  rb;
      logic [15:0] rs;
      reset = 1'b1; start = 1'b0; buttons = 5'b00000; sw16 = 16'h0000; sw8 = 8'h00;
      for (int i = 0; i < 3; i++) begin m_acc[i] = 0; m_ovf[i] = 1'b0; m_dbz[i] = 1'b0; end
      repeat (3) @(negedge clk);
      check_state("reset");
      reset = 1'b0;

      do_op(5'b00100, 16'd5, -1);
      do_op(5'b01000, 16'd8, -1);
      do_op(5'b00001, 16'd7, 5);
      do_op(5'b10000, 16'd4, -1);
      do_op(5'b10000, 16'd0, -1);
      do_op(5'b00100, 16'd0, -1);
      do_op(5'b00000, 16'd3, -1);
      do_op(5'b00010, 16'd0, -1);
      do_op(5'b00100, 16'd100, -1);
      do_op(5'b00100, 16'd100, -1);
      do_op(5'b00010, 16'd0, -1);
      do_op(5'b00100, 16'd16, -1);
      do_op(5'b00001, 16'd16, -1);
      do_op(5'b00010, 16'd0, -1);
      do_op(5'b00100, 16'hFF80, -1);
      do_op(5'b10000, 16'hFFFF, -1);
      do_op(5'b01111, 16'd9, -1);

      // Reset five cycles into a multiply: aborted, cleared, no done pulse
      @(negedge clk);
      for (int i = 0; i < 3; i++) base[i] = dcount[i];
      buttons = 5'b00001; sw16 = 16'd3; sw8 = 8'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin m_acc[i] = 0; m_ovf[i] = 1'b0; m_dbz[i] = 1'b0; end
      check_state("reset_mid_op");
      repeat (40) @(negedge clk);
      for (int i = 0; i < 3; i++) check("no_done_after_abort", i, dcount[i] - base[i], 0);

      // Reset together with start: start is dropped
      buttons = 5'b00100; sw16 = 16'd9; sw8 = 8'd9; start = 1'b1; reset = 1'b1;
      @(negedge clk);
      start = 1'b0; reset = 1'b0;
      repeat (3) @(negedge clk);
      check_state("reset_with_start");
      for (int i = 0; i < 3; i++) check("no_done_reset_start", i, dcount[i] - base[i], 0);

      do_op(5'b00100, 16'd11, -1);

      for (int t = 0; t < 40; t++) begin
         case ($urandom_range(0, 7))
            0: rb = 5'b00001;
            1: rb = 5'b00010;
            2: rb = 5'b00100;
            3: rb = 5'b01000;
            4, 5: rb = 5'b10000;
            6: rb = 5'($urandom);
            default: rb = 5'b00100;
         endcase
         case ($urandom_range(0, 3))
            0: rs = 16'($urandom_range(0, 3));
            1: rs = 16'hFFFF;
            default: rs = 16'($urandom);
         endcase
         do_op(rb, rs, (t % 4 == 0) ? 4 : -1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
